// File: rtl/oser_pkg.sv
// Shared types and sizing helpers for the output serializer.
// Define OSER_PARITY_EN to append an odd-parity bit to every frame.
package oser_pkg;

  typedef enum logic [0:0] {
    OSER_IDLE  = 1'b0,
    OSER_SHIFT = 1'b1
  } oser_state_e;

`ifdef OSER_PARITY_EN
  localparam int OSER_PAR_BITS = 1;
`else
  localparam int OSER_PAR_BITS = 0;
`endif

  // Bits per frame on the pad: data plus optional parity.
  function automatic int oser_frame_len(input int data_w);
    return data_w + OSER_PAR_BITS;
  endfunction

  function automatic int oser_cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/oser_gearbox_tx_if.sv
// Fabric-side word interface of the output serializer.
// Handshake: a word moves when DV & DRDY are high at an enabled SCLK edge; the
// source holds D and DV steady until that edge, and D is sampled only there.
interface oser_gearbox_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] D;
  logic              DV;
  logic              DRDY;

  modport master (output D, output DV, input DRDY);
  modport slave  (input D, input DV, output DRDY);
endinterface

// File: rtl/oser_hold_buf.sv
// Single-entry holding register between the fabric handshake and the shifter.
// It may be drained and refilled at the same edge.
module oser_hold_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              dv_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              drain_i,
  output logic              drdy_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);
  logic              full_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;

  // drain_i already includes the enable, so a draining entry frees the slot now.
  assign drdy_o = ~full_q | drain_i;
  assign accept = dv_i & drdy_o & en_i;
  assign full_o = full_q;
  assign data_o = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      data_q <= d_i;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/oser_gearbox_tx.sv
// Output serializer: holding register plus shifter driving a registered pad
// output Q with tristate TQ. Define OSER_PARITY_EN for an odd-parity bit.
module oser_gearbox_tx
  import oser_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic               SCLK,
  input  logic               CD,
  input  logic               SP,
  oser_gearbox_tx_if.slave   fab,
  output logic               Q,
  output logic               TQ,
  output logic               BUSY,
  output logic               LAST
);
  localparam int FRAME_W = oser_frame_len(DATA_W);
  localparam int CNT_W   = oser_cnt_width(DATA_W);

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              drain;

  oser_state_e       state_q;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_q;
  logic              tq_q;
  logic              last_q;
`ifdef OSER_PARITY_EN
  logic              par_q;
`endif

  logic              load_bit;
  logic [DATA_W-1:0] load_rest;
  logic              next_bit;
  logic [DATA_W-1:0] next_rest;

  // Holding register empties into the shifter when idle or on the frame's last bit.
  assign drain = SP & hold_full & ((state_q == OSER_IDLE) | last_q);

  oser_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk     (SCLK),
    .rst     (CD),
    .en_i    (SP),
    .dv_i    (fab.DV),
    .d_i     (fab.D),
    .drain_i (drain),
    .drdy_o  (fab.DRDY),
    .full_o  (hold_full),
    .data_o  (hold_data)
  );

  always_comb begin
    load_bit  = 1'b0;
    load_rest = '0;
    next_bit  = 1'b0;
    next_rest = '0;
    if (MSB_FIRST) begin
      load_bit  = hold_data[DATA_W-1];
      load_rest = {hold_data[DATA_W-2:0], 1'b0};
      next_bit  = sh_q[DATA_W-1];
      next_rest = {sh_q[DATA_W-2:0], 1'b0};
    end else begin
      load_bit  = hold_data[0];
      load_rest = {1'b0, hold_data[DATA_W-1:1]};
      next_bit  = sh_q[0];
      next_rest = {1'b0, sh_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge SCLK) begin
    if (CD) begin
      state_q <= OSER_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      q_q     <= IDLE_LEVEL;
      tq_q    <= 1'b1;
      last_q  <= 1'b0;
`ifdef OSER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (SP) begin
      if (drain) begin
        state_q <= OSER_SHIFT;
        sh_q    <= load_rest;
        cnt_q   <= CNT_W'(FRAME_W - 1);
        q_q     <= load_bit;
        tq_q    <= 1'b0;
        last_q  <= 1'b0;
`ifdef OSER_PARITY_EN
        par_q   <= ~^hold_data;
`endif
      end else if (state_q == OSER_SHIFT) begin
        if (last_q) begin
          state_q <= OSER_IDLE;
          cnt_q   <= '0;
          q_q     <= IDLE_LEVEL;
          tq_q    <= 1'b1;
          last_q  <= 1'b0;
        end else begin
          cnt_q  <= cnt_q - CNT_W'(1);
          last_q <= (cnt_q == CNT_W'(1));
          sh_q   <= next_rest;
`ifdef OSER_PARITY_EN
          // Count 1 means the last data bit is on Q; parity follows it.
          q_q    <= (cnt_q == CNT_W'(1)) ? par_q : next_bit;
`else
          q_q    <= next_bit;
`endif
        end
      end
    end
  end

  assign Q    = q_q;
  assign TQ   = tq_q;
  assign LAST = last_q;
  assign BUSY = (state_q == OSER_SHIFT) | hold_full;
endmodule

// File: tb/tb_oser_gearbox_tx.sv
// Bench for oser_gearbox_tx: an MSB-first and an LSB-first instance share stimulus
// and are checked against a queue-of-frame-bits reference model.
module tb_oser_gearbox_tx;
  import oser_pkg::*;

  localparam int W  = 8;
  localparam int FL = oser_frame_len(W);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         cd = 1'b1;
  logic         sp = 1'b1;
  logic         dv_drv = 1'b0;
  logic [W-1:0] d_drv = '0;

  oser_gearbox_tx_if #(.DATA_W(W)) fm ();
  oser_gearbox_tx_if #(.DATA_W(W)) fl ();
  assign fm.D  = d_drv;
  assign fm.DV = dv_drv;
  assign fl.D  = d_drv;
  assign fl.DV = dv_drv;

  logic q_m, tq_m, busy_m, last_m;
  logic q_l, tq_l, busy_l, last_l;

  oser_gearbox_tx #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
    .SCLK(clk), .CD(cd), .SP(sp), .fab(fm.slave),
    .Q(q_m), .TQ(tq_m), .BUSY(busy_m), .LAST(last_m)
  );

  oser_gearbox_tx #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .SCLK(clk), .CD(cd), .SP(sp), .fab(fl.slave),
    .Q(q_l), .TQ(tq_l), .BUSY(busy_l), .LAST(last_l)
  );

  // ---------------- reference model ----------------
  // Each queue entry is {last, bit}; the front entry is what Q currently shows.
  logic [1:0]   mq[$];
  logic [1:0]   lq[$];
  logic [W-1:0] m_hold = '0;
  logic         m_full = 1'b0;
  logic         m_acc  = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < FL; i++) begin
      logic mb;
      logic lb;
      logic lst;
      lst = (i == FL - 1);
      if (i < W) begin
        mb = w[W-1-i];
        lb = w[i];
      end else begin
        mb = ~^w;
        lb = ~^w;
      end
      mq.push_back({lst, mb});
      lq.push_back({lst, lb});
    end
  endtask

  task automatic model_edge(input logic c, input logic s, input logic v,
                            input logic [W-1:0] dd);
    logic drdy_pre;
    m_acc = 1'b0;
    if (c) begin
      mq.delete();
      lq.delete();
      m_full = 1'b0;
    end else if (s) begin
      drdy_pre = !m_full || (mq.size() <= 1);
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        void'(lq.pop_front());
      end
      if (mq.size() == 0 && m_full) begin
        push_frame(m_hold);
        m_full = 1'b0;
      end
      if (v && drdy_pre) begin
        m_hold = dd;
        m_full = 1'b1;
        m_acc  = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic e_q_m, e_q_l, e_tq, e_last, e_busy, e_drdy;
    if (mq.size() > 0) begin
      e_q_m  = mq[0][0];
      e_q_l  = lq[0][0];
      e_tq   = 1'b0;
      e_last = mq[0][1];
    end else begin
      e_q_m  = 1'b1;
      e_q_l  = 1'b1;
      e_tq   = 1'b1;
      e_last = 1'b0;
    end
    e_busy = (mq.size() > 0) || m_full;
    e_drdy = !m_full || (sp && mq.size() <= 1);
    chk("m_q",    q_m,     e_q_m);
    chk("m_tq",   tq_m,    e_tq);
    chk("m_last", last_m,  e_last);
    chk("m_busy", busy_m,  e_busy);
    chk("m_drdy", fm.DRDY, e_drdy);
    chk("l_q",    q_l,     e_q_l);
    chk("l_tq",   tq_l,    e_tq);
    chk("l_last", last_l,  e_last);
    chk("l_busy", busy_l,  e_busy);
    chk("l_drdy", fl.DRDY, e_drdy);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic c, input logic s, input logic v,
                       input logic [W-1:0] dd);
    cd = c; sp = s; dv_drv = v; d_drv = dd;
    @(posedge clk);
    model_edge(c, s, v, dd);
    @(negedge clk);
    compare_model();
  endtask

  // Offer one word with SP=1 until accepted, then run until idle, collecting Q bits.
  task automatic send_collect(input logic [W-1:0] w, output logic [17:0] got_m,
                              output logic [17:0] got_l, output int n_low);
    logic pend;
    pend  = 1'b1;
    got_m = '0;
    got_l = '0;
    n_low = 0;
    for (int i = 0; i < FL + 4; i++) begin
      cycle(1'b0, 1'b1, pend, w);
      if (m_acc) pend = 1'b0;
      if (tq_m == 1'b0) begin
        got_m = {got_m[16:0], q_m};
        got_l = {got_l[16:0], q_l};
        n_low++;
      end
    end
  endtask

  typedef struct {
    logic         cd, sp, dv;
    logic [W-1:0] d;
    logic         eq, etq, elast, edrdy, ebusy;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] a5 = 8'hA5;
  logic [17:0]  got_m, got_l, exp_b;
  int           n_low;
  logic         pend, saw_drdy_low;
  logic [W-1:0] rd;
  logic         rv, rc, rs;
  int           stage;

  initial begin
    // Directed reset-then-one-word table with hand-derived values.
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
    for (int i = 0; i < FL; i++) begin
      logic b;
      b = (i < W) ? a5[W-1-i] : 1'b1;
      tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, b, 1'b0, (i == FL - 1), 1'b1, 1'b1});
    end
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].cd, tbl[i].sp, tbl[i].dv, tbl[i].d);
      chk("tbl_q",    q_m,     tbl[i].eq);
      chk("tbl_tq",   tq_m,    tbl[i].etq);
      chk("tbl_last", last_m,  tbl[i].elast);
      chk("tbl_drdy", fm.DRDY, tbl[i].edrdy);
      chk("tbl_busy", busy_m,  tbl[i].ebusy);
    end

    // Back-to-back A5 then 3C with DV held high.
    stage = 0; got_m = '0; n_low = 0; saw_drdy_low = 1'b0;
    for (int i = 0; i < 2 * FL + 6; i++) begin
      cycle(1'b0, 1'b1, stage < 2, (stage == 0) ? 8'hA5 : 8'h3C);
      if (m_acc) stage++;
      if (fm.DRDY == 1'b0) saw_drdy_low = 1'b1;
      if (tq_m == 1'b0) begin
        got_m = {got_m[16:0], q_m};
        n_low++;
      end
    end
`ifdef OSER_PARITY_EN
    exp_b = 18'b10100101_1_00111100_1;
`else
    exp_b = 18'b00_10100101_00111100;
`endif
    chk("b2b_bits", got_m == exp_b, 1'b1);
    chk("b2b_tq_low_len", n_low == 2 * FL, 1'b1);
    chk("b2b_drdy_low", saw_drdy_low, 1'b1);

    // SP gating: no accept with SP=0, then each bit held two cycles.
    cycle(1'b0, 1'b0, 1'b1, 8'hA5);
    chk("sp0_no_accept", busy_m, 1'b0);
    pend = 1'b1; got_m = '0; n_low = 0;
    for (int i = 0; i < 2 * FL + 4; i++) begin
      rs = (i % 2 == 0);
      cycle(1'b0, rs, pend, 8'hA5);
      if (m_acc) pend = 1'b0;
      if (tq_m == 1'b0) begin
        n_low++;
        if (rs) got_m = {got_m[16:0], q_m};
      end
    end
`ifdef OSER_PARITY_EN
    exp_b = 18'b00000000_0_10100101_1 >> 0;
    exp_b = {9'b0, 9'b10100101_1};
`else
    exp_b = {10'b0, 8'hA5};
`endif
    chk("sp_gate_bits", got_m == exp_b, 1'b1);
    chk("sp_gate_hold_len", n_low == 2 * FL, 1'b1);

    // Reset mid-word after the third bit of FF.
    cycle(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("mid_pre_tq", tq_m, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    chk("mid_rst_q",    q_m,     1'b1);
    chk("mid_rst_tq",   tq_m,    1'b1);
    chk("mid_rst_drdy", fm.DRDY, 1'b1);
    chk("mid_rst_busy", busy_m,  1'b0);
    send_collect(8'h5A, got_m, got_l, n_low);
`ifdef OSER_PARITY_EN
    exp_b = {9'b0, 9'b01011010_1};
`else
    exp_b = {10'b0, 8'h5A};
`endif
    chk("after_rst_bits", got_m == exp_b, 1'b1);
    chk("after_rst_len", n_low == FL, 1'b1);

    // LSB-first instance with 01; parity of 07 is 0.
    send_collect(8'h01, got_m, got_l, n_low);
`ifdef OSER_PARITY_EN
    exp_b = {9'b0, 9'b10000000_0};
`else
    exp_b = {10'b0, 8'b10000000};
`endif
    chk("lsb_01_bits", got_l == exp_b, 1'b1);
    send_collect(8'h07, got_m, got_l, n_low);
`ifdef OSER_PARITY_EN
    exp_b = {9'b0, 9'b00000111_0};
`else
    exp_b = {10'b0, 8'h07};
`endif
    chk("frame_07_bits", got_m == exp_b, 1'b1);

    // Randomized traffic; the source holds D/DV until its word is taken.
    rv = 1'b0; rd = '0;
    for (int i = 0; i < 600; i++) begin
      rc = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 3) != 0);
      if (!rv) begin
        rv = ($urandom_range(0, 2) != 0);
        rd = W'($urandom);
      end
      cycle(rc, rs, rv, rd);
      if (m_acc || rc) rv = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
